// File: rtl/board_click_ctl_if.sv
// Memory-side bus between a board click controller and its board_mem write/read port.
interface board_click_ctl_if #(
    parameter int unsigned ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [1:0]            mem_wdata;
    logic                  mem_we;
    logic [1:0]            mem_rdata;

    // Controller side drives address/data/strobe and receives read data
    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_rdata
    );

    // Memory side
    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/board_click_ctl.sv
// Converts mouse clicks on one game grid into board_mem cell writes:
// PLACE toggles ship cells within a budget, SHOOT records miss/hit,
// and a clear pulse sweeps the whole board back to empty.
module board_click_ctl #(
    parameter int unsigned X_POS        = 100,
    parameter int unsigned Y_POS        = 200,
    parameter int unsigned CELL_SHIFT   = 5,
    parameter int unsigned X_SIZE       = 12,
    parameter int unsigned Y_SIZE       = 12,
    parameter int unsigned X_ADDR_WIDTH = 4,
    parameter int unsigned Y_ADDR_WIDTH = 4,
    parameter int unsigned MAX_SHIPS    = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    mode,
    input  logic                    clear,
    input  logic [11:0]             mouse_x,
    input  logic [11:0]             mouse_y,
    input  logic                    mouse_left,
    board_click_ctl_if.master       mem,
    output logic [7:0]              ship_count,
    output logic                    shot_valid,
    output logic                    shot_hit,
    output logic                    busy
);

    localparam int unsigned XA   = X_ADDR_WIDTH;
    localparam int unsigned YA   = Y_ADDR_WIDTH;
    localparam int unsigned DW   = 13;
    localparam int unsigned CNTW = 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CALC   = 3'd1;
    localparam logic [2:0] S_READ   = 3'd2;
    localparam logic [2:0] S_DECIDE = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_CLEAR  = 3'd5;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_SHIP  = 2'b01;
    localparam logic [1:0] CELL_MISS  = 2'b10;
    localparam logic [1:0] CELL_HIT   = 2'b11;

    logic            sync1_q, sync2_q, prev_q, click_q;
    logic [2:0]      state_q, state_d;
    logic [XA-1:0]   x_idx_q, x_idx_d;
    logic [YA-1:0]   y_idx_q, y_idx_d;
    logic            mode_q, mode_d;
    logic            inc_q, inc_d, dec_q, dec_d;
    logic            we_q, we_d;
    logic [1:0]      wdata_q, wdata_d;
    logic            shot_valid_q, shot_valid_d;
    logic            shot_hit_q, shot_hit_d;
    logic            busy_q, busy_d;
    logic [CNTW-1:0] count_q, count_d;

    logic [DW-1:0]   dx_c, dy_c;
    logic            in_grid_c;
    logic            sweep_last_c;

    // Pointer offset from the grid origin; bit 12 is the sign
    assign dx_c = DW'(mouse_x) - DW'(X_POS);
    assign dy_c = DW'(mouse_y) - DW'(Y_POS);
    assign in_grid_c = ~dx_c[DW-1] && ~dy_c[DW-1]
                    && ((dx_c >> CELL_SHIFT) < DW'(X_SIZE))
                    && ((dy_c >> CELL_SHIFT) < DW'(Y_SIZE));
    assign sweep_last_c = (x_idx_q == XA'(X_SIZE - 1)) && (y_idx_q == YA'(Y_SIZE - 1));

    assign mem.mem_addr  = {y_idx_q, x_idx_q};
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_we    = we_q;
    assign ship_count    = count_q;
    assign shot_valid    = shot_valid_q;
    assign shot_hit      = shot_hit_q;
    assign busy          = busy_q;

    // Two-flop synchroniser on the button plus registered rising-edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            click_q <= 1'b0;
        end else begin
            sync1_q <= mouse_left;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            click_q <= sync2_q & ~prev_q;
        end
    end

    // Next-state and registered-output logic; clear overrides everything
    always_comb begin
        state_d      = state_q;
        x_idx_d      = x_idx_q;
        y_idx_d      = y_idx_q;
        mode_d       = mode_q;
        inc_d        = 1'b0;
        dec_d        = 1'b0;
        we_d         = 1'b0;
        wdata_d      = CELL_EMPTY;
        shot_valid_d = 1'b0;
        shot_hit_d   = 1'b0;
        count_d      = count_q;

        case (state_q)
            S_IDLE: begin
                if (click_q && enable) begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                mode_d = mode;
                if (enable && in_grid_c) begin
                    x_idx_d = XA'(dx_c >> CELL_SHIFT);
                    y_idx_d = YA'(dy_c >> CELL_SHIFT);
                    state_d = S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                state_d = S_DECIDE;
            end
            S_DECIDE: begin
                state_d = S_WRITE;
                if (!mode_q) begin
                    if (mem.mem_rdata == CELL_EMPTY && count_q < CNTW'(MAX_SHIPS)) begin
                        we_d    = 1'b1;
                        wdata_d = CELL_SHIP;
                        inc_d   = 1'b1;
                    end else if (mem.mem_rdata == CELL_SHIP) begin
                        we_d    = 1'b1;
                        wdata_d = CELL_EMPTY;
                        dec_d   = 1'b1;
                    end
                end else begin
                    if (mem.mem_rdata == CELL_EMPTY) begin
                        we_d         = 1'b1;
                        wdata_d      = CELL_MISS;
                        shot_valid_d = 1'b1;
                    end else if (mem.mem_rdata == CELL_SHIP) begin
                        we_d         = 1'b1;
                        wdata_d      = CELL_HIT;
                        shot_valid_d = 1'b1;
                        shot_hit_d   = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
                if (inc_q) begin
                    count_d = count_q + CNTW'(1);
                end else if (dec_q) begin
                    count_d = count_q - CNTW'(1);
                end
            end
            S_CLEAR: begin
                if (sweep_last_c) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else begin
                    we_d = 1'b1;
                    if (x_idx_q == XA'(X_SIZE - 1)) begin
                        x_idx_d = '0;
                        y_idx_d = y_idx_q + YA'(1);
                    end else begin
                        x_idx_d = x_idx_q + XA'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (clear) begin
            state_d      = S_CLEAR;
            x_idx_d      = '0;
            y_idx_d      = '0;
            we_d         = 1'b1;
            wdata_d      = CELL_EMPTY;
            shot_valid_d = 1'b0;
            shot_hit_d   = 1'b0;
            inc_d        = 1'b0;
            dec_d        = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            x_idx_q      <= '0;
            y_idx_q      <= '0;
            mode_q       <= 1'b0;
            inc_q        <= 1'b0;
            dec_q        <= 1'b0;
            we_q         <= 1'b0;
            wdata_q      <= CELL_EMPTY;
            shot_valid_q <= 1'b0;
            shot_hit_q   <= 1'b0;
            busy_q       <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            x_idx_q      <= x_idx_d;
            y_idx_q      <= y_idx_d;
            mode_q       <= mode_d;
            inc_q        <= inc_d;
            dec_q        <= dec_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            shot_valid_q <= shot_valid_d;
            shot_hit_q   <= shot_hit_d;
            busy_q       <= busy_d;
            count_q      <= count_d;
        end
    end

endmodule

// File: tb/tb_board_click_ctl.sv
// Directed bench for board_click_ctl with a board_mem model and a
// write/shot scoreboard driven from a small behavioural board model.
module tb_board_click_ctl;

    typedef struct packed {
        logic [7:0] addr;
        logic [1:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        mode;
    logic        clear;
    logic [11:0] mouse_x;
    logic [11:0] mouse_y;
    logic        mouse_left;
    logic [7:0]  ship_count;
    logic        shot_valid;
    logic        shot_hit;
    logic        busy;

    board_click_ctl_if #(.ADDR_WIDTH(8)) mem_if ();

    board_click_ctl dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .mode       (mode),
        .clear      (clear),
        .mouse_x    (mouse_x),
        .mouse_y    (mouse_y),
        .mouse_left (mouse_left),
        .mem        (mem_if),
        .ship_count (ship_count),
        .shot_valid (shot_valid),
        .shot_hit   (shot_hit),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // board_mem model: synchronous read, read-before-write
    logic [1:0] mem_model [256];
    always @(posedge clk) begin
        mem_if.mem_rdata <= mem_model[mem_if.mem_addr];
        if (mem_if.mem_we === 1'b1) mem_model[mem_if.mem_addr] <= mem_if.mem_wdata;
    end

    wr_t  wr_q[$];
    logic shot_q[$];
    int   checks = 0;
    int   failures = 0;
    int   tick_cnt = 0;
    int   last_we_tick = 0;
    int   we_total = 0;
    int   busy_run = 0;
    int   max_busy_run = 0;
    int   click_t0 = 0;
    int   exp_ships = 0;
    logic [1:0] board [12][12];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and score whatever the DUT emitted
    task automatic tick();
        wr_t  e;
        logic h;
        @(negedge clk);
        tick_cnt++;
        if (busy === 1'b1) begin
            busy_run++;
            if (busy_run > max_busy_run) max_busy_run = busy_run;
        end else begin
            busy_run = 0;
        end
        if (mem_if.mem_we === 1'b1) begin
            last_we_tick = tick_cnt;
            we_total++;
            if (wr_q.size() == 0) begin
                chk("unexpected_we", 32'(mem_if.mem_we), 32'd0);
            end else begin
                e = wr_q.pop_front();
                chk("we_addr", 32'(mem_if.mem_addr), 32'(e.addr));
                chk("we_data", 32'(mem_if.mem_wdata), 32'(e.data));
            end
        end
        if (shot_valid === 1'b1) begin
            if (shot_q.size() == 0) begin
                chk("unexpected_shot", 32'(shot_valid), 32'd0);
            end else begin
                h = shot_q.pop_front();
                chk("shot_hit", 32'(shot_hit), 32'(h));
            end
        end
    endtask

    task automatic expect_sweep();
        for (int y = 0; y < 12; y++) begin
            for (int x = 0; x < 12; x++) begin
                wr_q.push_back({4'(y), 4'(x), 2'b00});
                board[y][x] = 2'b00;
            end
        end
        exp_ships = 0;
    endtask

    // Predict the outcome of a click from the board model, then perform it
    task automatic click_at(input int mx, input int my);
        int dx, dy, cx, cy;
        dx = mx - 100;
        dy = my - 200;
        mouse_x = 12'(mx);
        mouse_y = 12'(my);
        if (enable && dx >= 0 && dy >= 0 && (dx / 32) < 12 && (dy / 32) < 12) begin
            cx = dx / 32;
            cy = dy / 32;
            if (!mode) begin
                if (board[cy][cx] == 2'b00 && exp_ships < 20) begin
                    wr_q.push_back({4'(cy), 4'(cx), 2'b01});
                    board[cy][cx] = 2'b01;
                    exp_ships++;
                end else if (board[cy][cx] == 2'b01) begin
                    wr_q.push_back({4'(cy), 4'(cx), 2'b00});
                    board[cy][cx] = 2'b00;
                    exp_ships--;
                end
            end else begin
                if (board[cy][cx] == 2'b00) begin
                    wr_q.push_back({4'(cy), 4'(cx), 2'b10});
                    shot_q.push_back(1'b0);
                    board[cy][cx] = 2'b10;
                end else if (board[cy][cx] == 2'b01) begin
                    wr_q.push_back({4'(cy), 4'(cx), 2'b11});
                    shot_q.push_back(1'b1);
                    board[cy][cx] = 2'b11;
                end
            end
        end
        max_busy_run = 0;
        click_t0 = tick_cnt;
        mouse_left = 1'b1;
        repeat (10) tick();
        mouse_left = 1'b0;
        repeat (4) tick();
        chk("drain_writes", 32'(wr_q.size()), 32'd0);
        chk("drain_shots", 32'(shot_q.size()), 32'd0);
        chk("ship_count", 32'(ship_count), 32'(exp_ships));
        chk("busy_after", 32'(busy), 32'd0);
    endtask

    int start;

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        mode = 1'b0;
        clear = 1'b0;
        mouse_x = '0;
        mouse_y = '0;
        mouse_left = 1'b0;
        repeat (3) tick();
        chk("rst_we", 32'(mem_if.mem_we), 32'd0);
        chk("rst_wdata", 32'(mem_if.mem_wdata), 32'd0);
        chk("rst_addr", 32'(mem_if.mem_addr), 32'd0);
        chk("rst_ships", 32'(ship_count), 32'd0);
        chk("rst_shot", 32'({shot_valid, shot_hit}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Full-board clear sweep
        expect_sweep();
        start = tick_cnt;
        we_total = 0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (150) tick();
        chk("clear_drain", 32'(wr_q.size()), 32'd0);
        chk("clear_we_count", 32'(we_total), 32'd144);
        chk("clear_last_tick", 32'(last_we_tick - start), 32'd144);
        chk("clear_last_addr", 32'(mem_if.mem_addr), 32'h0BB);
        chk("clear_ships", 32'(ship_count), 32'd0);
        chk("clear_busy", 32'(busy), 32'd0);

        // PLACE toggle at the grid origin, with edge-to-write latency
        click_at(100, 200);
        chk("we_latency", 32'(last_we_tick - click_t0), 32'd7);
        click_at(100, 200);

        // Fill the ship budget, then a further placement is refused
        for (int i = 0; i < 20; i++) begin
            click_at(100 + 32 * (i % 12) + 5, 200 + 32 * (i / 12) + 5);
        end
        chk("budget_full", 32'(ship_count), 32'd20);
        click_at(483, 583);

        // Free one slot, place at cell 0x21, then shoot it
        click_at(100, 200);
        click_at(132, 264);
        mode = 1'b1;
        click_at(132, 264);
        click_at(132, 264);
        click_at(260, 360);

        // Out-of-grid pointers and disabled clicks
        mode = 1'b0;
        click_at(99, 200);
        chk("busy_run_left", 32'(max_busy_run <= 2), 32'd1);
        click_at(484, 200);
        chk("busy_run_right", 32'(max_busy_run <= 2), 32'd1);
        enable = 1'b0;
        click_at(100, 200);
        chk("busy_run_disabled", 32'(max_busy_run <= 2), 32'd1);
        enable = 1'b1;

        // Clear landing in DECIDE of a PLACE click, plus an edge during the sweep
        mouse_x = 12'd420;
        mouse_y = 12'd520;
        expect_sweep();
        mouse_left = 1'b1;
        repeat (6) tick();
        chk("decide_busy", 32'(busy), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        mouse_left = 1'b0;
        repeat (20) tick();
        mouse_left = 1'b1;
        repeat (140) tick();
        mouse_left = 1'b0;
        repeat (10) tick();
        chk("abort_drain", 32'(wr_q.size()), 32'd0);
        chk("abort_ships", 32'(ship_count), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);

        // Still operational after the aborted click
        click_at(420, 520);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
